// File: rtl/anton_pm_driver.sv
// Host-side driver that bit-bangs a nibble-wide accumulator target through its io pins,
// keeping a shadow copy of the accumulator to cross-check destructive read-backs.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for a command, dut_clk low, cmd_ready high
// S_LOW  | dut_clk low phase of a target edge, pins set up
// S_HIGH | dut_clk high phase, target result sampled in last cycle
// S_DONE | one-cycle wrap-up: response pulse and shadow update
module anton_pm_driver #(
    parameter int HALF_PERIOD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [23:0] rsp_data,
    output logic        rsp_mismatch,
    output logic        sub_next,
    output logic        dut_clk,
    output logic        dut_reset,
    output logic        dut_read,
    output logic [3:0]  dut_nibble,
    input  logic [7:0]  dut_result
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_READ = 2'b01;
    localparam logic [1:0] OP_TRST = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;
    localparam logic [7:0] PH_LOAD = 8'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  ph_cnt;
    logic [1:0]  edge_left;
    logic [1:0]  op_q;
    logic [7:0]  data_q;
    logic [15:0] rd_buf;
    logic [23:0] shadow;
    logic        accept;
    logic        ph_tc;
    logic [23:0] rd_word;

    assign accept  = cmd_valid && cmd_ready;
    assign ph_tc   = (ph_cnt == 8'd0);
    assign rd_word = {dut_result, rd_buf};

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = (cmd_op == OP_NOP) ? S_DONE : S_LOW;
            S_LOW:  if (ph_tc) state_nx = S_HIGH;
            S_HIGH: if (ph_tc) state_nx = (edge_left == 2'd0) ? S_DONE : S_LOW;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_data     <= 24'd0;
            rsp_mismatch <= 1'b0;
            sub_next     <= 1'b0;
            dut_clk      <= 1'b0;
            dut_reset    <= 1'b0;
            dut_read     <= 1'b0;
            dut_nibble   <= 4'd0;
            ph_cnt       <= 8'd0;
            edge_left    <= 2'd0;
            op_q         <= OP_NOP;
            data_q       <= 8'd0;
            rd_buf       <= 16'd0;
            shadow       <= 24'd0;
        end else begin
            state        <= state_nx;
            cmd_ready    <= (state_nx == S_IDLE);
            dut_clk      <= (state_nx == S_HIGH);
            rsp_valid    <= 1'b0;
            rsp_data     <= 24'd0;
            rsp_mismatch <= 1'b0;

            // phase timer reloads on every state change, counts down otherwise
            if (state_nx != state)
                ph_cnt <= PH_LOAD;
            else if (!ph_tc)
                ph_cnt <= ph_cnt - 8'd1;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= cmd_op;
                        data_q <= cmd_data;
                        if (cmd_op != OP_NOP) begin
                            dut_read  <= (cmd_op == OP_READ);
                            dut_reset <= (cmd_op == OP_TRST);
                            if (cmd_op == OP_PUSH)
                                dut_nibble <= cmd_data[3:0];
                        end
                        case (cmd_op)
                            OP_PUSH: edge_left <= 2'd1;
                            OP_READ: edge_left <= 2'd2;
                            default: edge_left <= 2'd0;
                        endcase
                    end
                end
                S_HIGH: begin
                    if (ph_tc) begin
                        if (op_q == OP_READ) begin
                            if (edge_left == 2'd2)
                                rd_buf[7:0] <= dut_result;
                            else if (edge_left == 2'd1)
                                rd_buf[15:8] <= dut_result;
                            else begin
                                rsp_valid    <= 1'b1;
                                rsp_data     <= rd_word;
                                rsp_mismatch <= (rd_word != shadow);
                            end
                        end
                        if (edge_left != 2'd0) begin
                            edge_left <= edge_left - 2'd1;
                            if (op_q == OP_PUSH)
                                dut_nibble <= data_q[7:4];
                        end else begin
                            dut_read  <= 1'b0;
                            dut_reset <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    case (op_q)
                        OP_PUSH: begin
                            shadow   <= sub_next ? shadow - {16'd0, data_q}
                                                 : shadow + {16'd0, data_q};
                            sub_next <= ~sub_next;
                        end
                        OP_READ: shadow <= 24'd0;
                        OP_TRST: begin
                            shadow   <= 24'd0;
                            sub_next <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/anton_pm_driver.md
ANTON_PM_DRIVER -- requirements
Module: anton_pm_driver

Interface
REQ-001 Parameter HALF_PERIOD, default 1, driver clk cycles per dut_clk phase (legal 1..255).
REQ-002 clk  in  1  single driver clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_op  in  2  00 push byte, 01 read back, 10 target reset, 11 no-op.
REQ-006 cmd_data  in  8  byte for push; ignored otherwise.
REQ-007 cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-008 rsp_valid  out  1  one-cycle pulse, read data valid; no backpressure.
REQ-009 rsp_data  out  24  read-back accumulator {byte2,byte1,byte0}.
REQ-010 rsp_mismatch  out  1  valid with rsp_valid; rsp_data != shadow accumulator.
REQ-011 sub_next  out  1  next push is subtracted (shadow of target mode bit).
REQ-012 dut_clk, dut_reset, dut_read  out  1 each  drive target io_in[0], io_in[1], io_in[2].
REQ-013 dut_nibble  out  4  drives target io_in[7:4].
REQ-014 dut_result  in  8  target io_out.

Function
REQ-015 All outputs are registers.
REQ-016 FSM states: IDLE, LOW, HIGH, DONE.
REQ-017 Target edge: LOW phase (dut_clk=0) for HALF_PERIOD cycles, then HIGH phase (dut_clk=1) for HALF_PERIOD cycles.
REQ-018 dut_reset/dut_read/dut_nibble change only on entry to LOW; stable through HIGH.
REQ-019 IDLE: dut_clk=0, dut_reset=0, dut_read=0, dut_nibble holds last value.
REQ-020 Accept in cycle T -> LOW begins at T+1.
REQ-021 Push: 2 edges, read=0; edge 1 nibble=cmd_data[3:0], edge 2 nibble=cmd_data[7:4].
REQ-022 Read: 3 edges, read=1; dut_result sampled in the last HIGH cycle of edge k into byte k (k=0,1,2).
REQ-023 Target reset: 1 edge, dut_reset=1, read=0.
REQ-024 No-op: no edges; DONE at T+1, IDLE at T+2.
REQ-025 After final HIGH -> DONE for 1 cycle (cmd_ready=0) -> IDLE.
REQ-026 Busy span, accept to cmd_ready re-high: push 4*H+1, read 6*H+1, reset 2*H+1 cycles (H=HALF_PERIOD).
REQ-027 rsp_valid/rsp_data/rsp_mismatch pulse in DONE of a read only.
REQ-028 cmd_valid while cmd_ready=0 is ignored, not queued.
REQ-029 Shadow acc (24 bit, mod 2^24): push adds or subtracts {cmd_data} per sub_next, then sub_next toggles; both updates in DONE.
REQ-030 Read clears shadow to 0 (destructive read); sub_next unchanged.
REQ-031 Target reset clears shadow and sub_next.
REQ-032 rsp_mismatch compares assembled rsp_data with pre-read shadow value.

Reset
REQ-033 Reset in any state -> IDLE next cycle: cmd_ready=1, dut_clk=0, dut_reset=0, dut_read=0, dut_nibble=0, rsp_valid=0, rsp_data=0, rsp_mismatch=0, sub_next=0, shadow=0, counters=0.
REQ-034 Reset mid-operation aborts remaining edges with no rsp pulse; target state is then unknown and the host issues op 10 before relying on shadow.
REQ-035 Reset has priority over a same-cycle command.

Verification
REQ-036 H=1: op10, push 0x25, push 0x10, read -> rsp_data=0x000015, mismatch=0, sub_next=0.
REQ-037 Push 0xA7 -> dut_nibble=7 in edge 1, 0xA in edge 2, exactly 2 dut_clk rises, cmd_ready low 5 cycles.
REQ-038 op10, push 0x00, push 0x01, read -> 0xFFFFFF (wrap); second read -> 0x000000.
REQ-039 H=3, cmd_valid held high across busy window with op 01 -> one read only, 3 rises, rsp_valid once at accept+19.
REQ-040 Reset asserted during HIGH of push edge 1 -> next cycle dut_clk=0, cmd_ready=1, sub_next=0, no further rises.
REQ-041 Target model corrupted to add 1 extra -> read pulses rsp_mismatch=1.
